// File: rtl/avreg_pkg.sv
// Shared definitions for avalon_reg_decoder: FSM state encoding and default
// parameter values (including the default card-owned register mask).
package avreg_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_BUSY = 3'd1;
   localparam logic [2:0] WR_DONE   = 3'd2;
   localparam logic [2:0] RD_DONE   = 3'd3;
   localparam logic [2:0] ABORT     = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = IDLE,
      ST_WAIT_BUSY = WAIT_BUSY,
      ST_WR_DONE   = WR_DONE,
      ST_RD_DONE   = RD_DONE,
      ST_ABORT     = ABORT
   } avreg_state_t;

   localparam int         AVREG_ADDR_W      = 3;
   localparam int         AVREG_NUM_REGS    = 6;
   localparam int         AVREG_DATA_W      = 8;
   localparam int         AVREG_TIMEOUT_CYC = 256;
   localparam logic [5:0] AVREG_BUSY_MASK   = 6'b011000;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational word-address to one-hot select; o_in_range is low for any
// address at or beyond NUM_REGS (the one-hot output is then all zero).
module onehot_decoder
   import avreg_pkg::*;
#(
   parameter int ADDR_W   = AVREG_ADDR_W,
   parameter int NUM_REGS = AVREG_NUM_REGS
) (
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [NUM_REGS-1:0] o_onehot,
   output logic                o_in_range
);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_onehot[i] = (i_addr == ADDR_W'(i));
      end
   end

   assign o_in_range = |o_onehot;

endmodule

// File: rtl/avalon_reg_decoder.sv
// Avalon-MM slave front end for the HPS<->card register file: one-hot strobes,
// registered read-back, waitrequest flow control and card-busy write holding.
// Define AVREG_DECODER_TIMEOUT_EN to add the busy-wait timeout / ABORT path.
module avalon_reg_decoder
   import avreg_pkg::*;
#(
   parameter int                  ADDR_W      = AVREG_ADDR_W,
   parameter int                  NUM_REGS    = AVREG_NUM_REGS,
   parameter int                  DATA_W      = AVREG_DATA_W,
   parameter logic [NUM_REGS-1:0] BUSY_MASK   = NUM_REGS'(AVREG_BUSY_MASK),
   parameter int                  TIMEOUT_CYC = AVREG_TIMEOUT_CYC
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_chipselect,
   input  logic [ADDR_W-1:0]            i_address,
   input  logic                         i_read,
   input  logic                         i_write,
   input  logic [DATA_W-1:0]            i_writedata,
   output logic [DATA_W-1:0]            o_readdata,
   output logic                         o_waitrequest,
   output logic [NUM_REGS-1:0]          o_wr_strobe,
   output logic [NUM_REGS-1:0]          o_rd_strobe,
   output logic [DATA_W-1:0]            o_wr_data,
   input  logic [NUM_REGS*DATA_W-1:0]   i_reg_rdata,
   input  logic [NUM_REGS-1:0]          i_reg_busy,
   input  logic                         i_err_clr,
   output logic                         o_err_range,
   output logic                         o_err_timeout
);

   if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W) || TIMEOUT_CYC < 2) begin : g_param_chk
      $error("avalon_reg_decoder: illegal NUM_REGS/ADDR_W/TIMEOUT_CYC");
   end

   avreg_state_t        r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   w_dec_addr;
   logic [NUM_REGS-1:0] w_onehot;
   logic                w_in_range;
   logic                w_busy_hit;
   logic                w_req;
   logic                w_cnt_max;
   logic                w_ld_idx;
   logic                w_ld_rdata;
   logic                w_set_range;
   logic [DATA_W-1:0]   r_readdata;
   logic [DATA_W-1:0]   w_rd_slice;
   logic                r_err_range;

   // One decoder serves both phases: live address while IDLE, latched target after.
   assign w_dec_addr = (r_state == ST_IDLE) ? i_address : r_idx;

   onehot_decoder #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .i_addr     (w_dec_addr),
      .o_onehot   (w_onehot),
      .o_in_range (w_in_range)
   );

   assign w_busy_hit = |(w_onehot & i_reg_busy & BUSY_MASK);
   assign w_req      = i_chipselect & (i_read | i_write);
   assign o_wr_data  = i_writedata;
   assign o_readdata = r_readdata;
   assign o_err_range = r_err_range;

   always_comb begin
      w_rd_slice = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_onehot[i]) w_rd_slice = w_rd_slice | i_reg_rdata[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_readdata  <= '0;
         r_err_range <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_idx)   r_idx      <= i_address;
         if (w_ld_rdata) r_readdata <= w_rd_slice;
         if (w_set_range)    r_err_range <= 1'b1;
         else if (i_err_clr) r_err_range <= 1'b0;
      end
   end

`ifdef AVREG_DECODER_TIMEOUT_EN
   localparam int              CNT_W   = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err_timeout;

   // Held at its maximum while leaving for ABORT so it never wraps.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt         <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (r_state != ST_WAIT_BUSY) r_cnt <= '0;
         else if (!w_cnt_max)         r_cnt <= r_cnt + 1'b1;
         if (r_state == ST_ABORT) r_err_timeout <= 1'b1;
         else if (i_err_clr)      r_err_timeout <= 1'b0;
      end
   end

   assign w_cnt_max     = (r_cnt == CNT_MAX);
   assign o_err_timeout = r_err_timeout;
`else
   assign w_cnt_max     = 1'b0;
   assign o_err_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_ld_idx      = 1'b0;
      w_ld_rdata    = 1'b0;
      w_set_range   = 1'b0;
      o_waitrequest = 1'b1;
      o_wr_strobe   = '0;
      o_rd_strobe   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               w_ld_idx = 1'b1;
               if (!w_in_range) begin
                  // w_rd_slice is zero here, so readdata clears
                  w_set_range = 1'b1;
                  w_ld_rdata  = 1'b1;
                  w_state_nxt = i_write ? ST_WR_DONE : ST_RD_DONE;
               end else if (i_write) begin
                  w_state_nxt = w_busy_hit ? ST_WAIT_BUSY : ST_WR_DONE;
               end else begin
                  w_ld_rdata  = 1'b1;
                  w_state_nxt = ST_RD_DONE;
               end
            end
         end
         ST_WAIT_BUSY: begin
            if (!w_busy_hit)    w_state_nxt = ST_WR_DONE;
            else if (w_cnt_max) w_state_nxt = ST_ABORT;
         end
         ST_WR_DONE: begin
            o_waitrequest = 1'b0;
            o_wr_strobe   = w_onehot;
            w_state_nxt   = ST_IDLE;
         end
         ST_RD_DONE: begin
            o_waitrequest = 1'b0;
            o_rd_strobe   = w_onehot;
            w_state_nxt   = ST_IDLE;
         end
         ST_ABORT: begin
            o_waitrequest = 1'b0;
            w_state_nxt   = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_avalon_reg_decoder.sv
// Directed + randomized bench for avalon_reg_decoder against a transaction-level
// model (latency, strobes, read data and sticky errors per Avalon transfer).
module tb_avalon_reg_decoder;

   localparam int         NR = 6;
   localparam int         TO = 8;
   localparam logic [5:0] BM = 6'b011000;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_chipselect = 1'b0;
   logic [2:0]    i_address = '0;
   logic          i_read = 1'b0;
   logic          i_write = 1'b0;
   logic [7:0]    i_writedata = '0;
   logic [7:0]    o_readdata;
   logic          o_waitrequest;
   logic [5:0]    o_wr_strobe;
   logic [5:0]    o_rd_strobe;
   logic [7:0]    o_wr_data;
   logic [47:0]   i_reg_rdata = '0;
   logic [5:0]    i_reg_busy = '0;
   logic          i_err_clr = 1'b0;
   logic          o_err_range;
   logic          o_err_timeout;

   int n_pass = 0;
   int n_tot  = 0;

   // transaction-level model state
   logic [7:0] m_rd = '0;
   bit         m_err_r = 0;
   bit         m_err_t = 0;

   avalon_reg_decoder #(
      .ADDR_W(3), .NUM_REGS(NR), .DATA_W(8), .BUSY_MASK(BM), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_chipselect(i_chipselect),
      .i_address(i_address), .i_read(i_read), .i_write(i_write),
      .i_writedata(i_writedata), .o_readdata(o_readdata),
      .o_waitrequest(o_waitrequest), .o_wr_strobe(o_wr_strobe),
      .o_rd_strobe(o_rd_strobe), .o_wr_data(o_wr_data),
      .i_reg_rdata(i_reg_rdata), .i_reg_busy(i_reg_busy),
      .i_err_clr(i_err_clr), .o_err_range(o_err_range),
      .o_err_timeout(o_err_timeout)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One Avalon transfer; target busy bit high for busy_n cycles from cycle 1.
   task automatic xact(input bit wr, input bit rd, input logic [2:0] a, input logic [7:0] d,
                       input int busy_n, input bit clr, input string tag);
      int cyc, nstb, exp_cyc;
      bit done, in_rng, masked, abort;
      logic [5:0] tgt, wsb, rsb, ewsb, ersb;
      logic [7:0] rdat, wdat;
      in_rng = (int'(a) < NR);
      tgt    = in_rng ? (6'd1 << a) : 6'd0;
      masked = wr && ((tgt & BM) != 0);
      abort  = 1'b0;
      exp_cyc = (masked && busy_n > 0) ? busy_n + 2 : 2;
`ifdef AVREG_DECODER_TIMEOUT_EN
      if (masked && busy_n > TO) begin
         abort   = 1'b1;
         exp_cyc = TO + 2;
      end
`endif
      ewsb = (wr && !abort) ? tgt : 6'd0;
      ersb = (!wr) ? tgt : 6'd0;
      if (clr) begin m_err_r = 0; m_err_t = 0; end
      if (!in_rng) begin m_err_r = 1; m_rd = '0; end
      else if (!wr) m_rd = i_reg_rdata[int'(a)*8 +: 8];
      if (abort) m_err_t = 1;

      cyc = 0; nstb = 0; done = 0; wsb = '0; rsb = '0; rdat = 'x; wdat = 'x;
      while (!done && cyc < 400) begin
         @(negedge i_clk);
         cyc++;
         if (cyc > 1) begin
            if (o_wr_strobe != 0 || o_rd_strobe != 0) nstb++;
            wsb = wsb | o_wr_strobe;
            rsb = rsb | o_rd_strobe;
            if (!o_waitrequest) begin
               done = 1; rdat = o_readdata; wdat = o_wr_data;
            end
         end
         if (done) begin
            i_chipselect = 0; i_read = 0; i_write = 0; i_reg_busy = '0;
         end else begin
            i_chipselect = 1; i_read = rd; i_write = wr; i_writedata = d;
            // address is only meaningful at the request edge
            i_address  = (cyc == 1) ? a : 3'($urandom_range(0, 7));
            i_reg_busy = (6'($urandom) & ~tgt) | ((cyc <= busy_n) ? tgt : 6'd0);
         end
         i_err_clr = clr && (cyc == 1);
      end
      i_err_clr = 0;
      chk({tag, "/cycles"}, cyc, exp_cyc);
      chk({tag, "/wr_strobe"}, wsb, ewsb);
      chk({tag, "/rd_strobe"}, rsb, ersb);
      chk({tag, "/strobe_cycles"}, nstb, ((ewsb | ersb) != 0) ? 1 : 0);
      chk({tag, "/readdata"}, rdat, m_rd);
      if (wr) chk({tag, "/wr_data"}, wdat, d);
      @(negedge i_clk);
      chk({tag, "/idle_after"}, {o_waitrequest, o_wr_strobe, o_rd_strobe}, {1'b1, 12'd0});
      chk({tag, "/err_range"}, o_err_range, m_err_r);
      chk({tag, "/err_timeout"}, o_err_timeout, m_err_t);
   endtask

   task automatic clr_pulse(input string tag);
      @(negedge i_clk); i_err_clr = 1;
      @(negedge i_clk); i_err_clr = 0;
      m_err_r = 0; m_err_t = 0;
      chk({tag, "/err_range"}, o_err_range, 0);
      chk({tag, "/err_timeout"}, o_err_timeout, 0);
   endtask

   initial begin
      bit wr, rd;
      logic [5:0] acc;
      repeat (3) @(negedge i_clk);
      i_reset = 0;
      @(negedge i_clk);
      chk("reset/waitrequest", o_waitrequest, 1);
      chk("reset/strobes", {o_wr_strobe, o_rd_strobe}, 0);
      chk("reset/readdata", o_readdata, 0);
      chk("reset/errors", {o_err_range, o_err_timeout}, 0);

      i_reg_rdata = {8'h66, 8'h55, 8'h44, 8'h33, 8'h3C, 8'h11};
      xact(1, 0, 3'd2, 8'hA5, 0, 0, "wr2");
      xact(0, 1, 3'd1, 8'h00, 0, 0, "rd1");
      xact(1, 0, 3'd3, 8'h77, 5, 0, "wr3_busy5");
      xact(1, 0, 3'd2, 8'h12, 6, 0, "wr2_unmasked_busy");
`ifdef AVREG_DECODER_TIMEOUT_EN
      xact(1, 0, 3'd4, 8'h5A, 1000, 0, "wr4_timeout");
`else
      xact(1, 0, 3'd4, 8'h5A, 20, 0, "wr4_longbusy");
`endif
      clr_pulse("clr1");
      xact(0, 1, 3'd7, 8'h00, 0, 0, "rd7_range");
      xact(1, 1, 3'd0, 8'hC3, 0, 0, "rdwr0");
      xact(1, 0, 3'd6, 8'h99, 0, 1, "wr6_clr_same_cycle");
      clr_pulse("clr2");

      // reset while a masked write is waiting on busy
      @(negedge i_clk);
      i_chipselect = 1; i_write = 1; i_address = 3'd3; i_reg_busy = 6'b001000;
      @(negedge i_clk);
      @(negedge i_clk); i_reset = 1;
      @(negedge i_clk); i_reset = 0; i_chipselect = 0; i_write = 0; i_reg_busy = '0;
      m_rd = '0; m_err_r = 0; m_err_t = 0;
      chk("rst_mid/waitrequest", o_waitrequest, 1);
      chk("rst_mid/strobes", {o_wr_strobe, o_rd_strobe}, 0);
      acc = '0;
      repeat (4) begin
         @(negedge i_clk);
         acc = acc | o_wr_strobe | o_rd_strobe | {5'd0, ~o_waitrequest};
      end
      chk("rst_mid/no_late_write", acc, 0);
      chk("rst_mid/readdata", o_readdata, 0);

      for (int k = 0; k < 60; k++) begin
         i_reg_rdata = {$urandom, $urandom};
         wr = 1'($urandom);
         rd = wr ? 1'($urandom) : 1'b1;
         xact(wr, rd, 3'($urandom_range(0, 7)), 8'($urandom),
              int'($urandom_range(0, 12)), ($urandom_range(0, 7) == 0), $sformatf("rand%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
